// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-port RAM: a write takes 2 cycles from grant to done, a read RD_LAT+1.
// Requesters wait in IDLE by holding req. Round-robin by default; define ARB_FIXED_PRIO_EN to give m0 strict priority.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write_enable,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [1:0] CNT_LAST = 2'(RD_LAT - 1);

    state_t     state;
    state_t     state_nxt;
    logic       owner;
    logic       acc_we;
    logic [1:0] cnt;
    logic       any_req;
    logic       pick;

    assign any_req = m0_req || m1_req;

`ifdef ARB_FIXED_PRIO_EN
    assign pick = !m0_req;
`else
    logic ptr;

    // The pointer only matters on a tie; a lone requester always wins.
    assign pick = (m0_req && m1_req) ? ptr : m1_req;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        m0_gnt           = 1'b0;
        m1_gnt           = 1'b0;
        m0_done          = 1'b0;
        m1_done          = 1'b0;
        ram_write_enable = 1'b0;
        busy             = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                busy             = 1'b1;
                m0_gnt           = !owner;
                m1_gnt           = owner;
                ram_write_enable = acc_we;
                if (acc_we || cnt == CNT_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                m0_gnt    = !owner;
                m1_gnt    = owner;
                m0_done   = !owner;
                m1_done   = owner;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            owner       <= 1'b0;
            acc_we      <= 1'b0;
            cnt         <= 2'd0;
            ram_address <= '0;
            ram_data_in <= '0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
`ifndef ARB_FIXED_PRIO_EN
            ptr         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner       <= pick;
                        acc_we      <= pick ? m1_we : m0_we;
                        ram_address <= pick ? m1_addr : m0_addr;
                        cnt         <= 2'd0;
                        if (pick ? m1_we : m0_we) begin
                            ram_data_in <= pick ? m1_wdata : m0_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (!acc_we) begin
                        if (cnt == CNT_LAST) begin
                            if (owner) begin
                                m1_rdata <= ram_data_out;
                            end else begin
                                m0_rdata <= ram_data_out;
                            end
                        end else begin
                            cnt <= cnt + 2'd1;
                        end
                    end
                end
                DONE: begin
`ifndef ARB_FIXED_PRIO_EN
                    ptr <= !owner;
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule
